// File: rtl/controle_lampada.sv
// Lamp controller: four-state on/off FSM with soft-start/soft-stop duty ramps
// and a free-running 255-cycle PWM generator driving the lamp.
module controle_lampada #(
  parameter int unsigned RAMP_STEP_T = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A,
  input  logic       C,
  output logic       enable,
  output logic       lampada,
  output logic [7:0] duty,
  output logic       pwm_out
);

  typedef enum logic [1:0] {
    DESLIGADA = 2'd0,
    SUBINDO   = 2'd1,
    LIGADA    = 2'd2,
    DESCENDO  = 2'd3
  } estado_t;

  localparam logic [15:0] STEP_LAST = 16'(RAMP_STEP_T - 1);

  estado_t     estado, estado_next;
  logic [7:0]  duty_next;
  logic [15:0] step_cnt, step_next;
  logic [7:0]  pwm_cnt;
  logic        step_due;

  assign step_due = (step_cnt == STEP_LAST);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    estado_next = estado;
    duty_next   = duty;
    step_next   = step_cnt;
    unique case (estado)
      DESLIGADA: begin
        if (A) estado_next = SUBINDO;
      end
      SUBINDO: begin
        // Saturation check precedes the step so duty can never wrap past 255.
        if (duty == 8'hFF) begin
          estado_next = LIGADA;
        end else if (A) begin
          estado_next = DESCENDO;
        end else if (step_due) begin
          duty_next = duty + 8'd1;
          step_next = '0;
        end else begin
          step_next = step_cnt + 16'd1;
        end
      end
      LIGADA: begin
        if (A || C) estado_next = DESCENDO;
      end
      DESCENDO: begin
        if (duty == 8'h00) begin
          estado_next = DESLIGADA;
        end else if (A) begin
          estado_next = SUBINDO;
        end else if (step_due) begin
          duty_next = duty - 8'd1;
          step_next = '0;
        end else begin
          step_next = step_cnt + 16'd1;
        end
      end
      default: begin
        estado_next = DESLIGADA;
        duty_next   = '0;
      end
    endcase
    // A fresh state always starts a full step interval.
    if (estado_next != estado) step_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado   <= DESLIGADA;
      duty     <= '0;
      step_cnt <= '0;
    end else begin
      estado   <= estado_next;
      duty     <= duty_next;
      step_cnt <= step_next;
    end
  end

  // PWM period is 255 so duty=255 yields a constant high output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == 8'd254) ? 8'd0 : pwm_cnt + 8'd1;
      pwm_out <= (pwm_cnt < duty);
    end
  end

  assign enable  = (estado == LIGADA);
  assign lampada = (estado == SUBINDO) || (estado == LIGADA);

endmodule

// File: tb/tb_controle_lampada.sv
// Bench for controle_lampada: ramp model built from entry time and entry duty,
// checked every cycle, plus directed checks at hand-computed cycle offsets.
module tb_controle_lampada;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0;
  logic       c = 1'b0;
  logic       enable, lampada, pwm_out;
  logic [7:0] duty;

  controle_lampada #(.RAMP_STEP_T(T)) dut (
    .clk     (clk),
    .rst     (rst),
    .A       (a),
    .C       (c),
    .enable  (enable),
    .lampada (lampada),
    .duty    (duty),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0=off 1=ramping up 2=on 3=ramping down. Duty during a ramp is the
  // entry duty moved by one LSB per T edges elapsed since entry, clamped.
  int m_mode  = 0;
  int m_base  = 0;
  int m_entry = 0;
  int m_edges = 0;
  int exp_pwm = 0;

  function automatic int cur_duty();
    int k, v;
    k = (m_edges - m_entry) / T;
    case (m_mode)
      1:       v = (m_base + k > 255) ? 255 : m_base + k;
      3:       v = (m_base - k < 0) ? 0 : m_base - k;
      default: v = m_base;
    endcase
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_base = 0; m_entry = 0; m_edges = 0; exp_pwm = 0;
    end else begin
      int d;
      d = cur_duty();
      exp_pwm = ((m_edges % 255) < d) ? 1 : 0;
      m_edges++;
      case (m_mode)
        0: if (a) begin m_mode = 1; m_base = d; m_entry = m_edges; end
        1: if (d == 255) begin m_mode = 2; m_base = 255; m_entry = m_edges; end
           else if (a) begin m_mode = 3; m_base = d; m_entry = m_edges; end
        2: if (a || c) begin m_mode = 3; m_base = 255; m_entry = m_edges; end
        default: if (d == 0) begin m_mode = 0; m_base = 0; m_entry = m_edges; end
                 else if (a) begin m_mode = 1; m_base = d; m_entry = m_edges; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("cyc_duty",    int'(duty),    cur_duty());
      check("cyc_enable",  int'(enable),  (m_mode == 2) ? 1 : 0);
      check("cyc_lampada", int'(lampada), (m_mode == 1 || m_mode == 2) ? 1 : 0);
      check("cyc_pwm",     int'(pwm_out), exp_pwm);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic pa, input logic pc);
    a = pa; c = pc;
    @(negedge clk);
    a = 1'b0; c = 1'b0;
  endtask

  initial begin
    int ones;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tick(50);
    check("idle_duty", int'(duty), 0);
    check("idle_en",   int'(enable), 0);
    check("idle_lamp", int'(lampada), 0);
    check("idle_pwm",  int'(pwm_out), 0);

    // Full ramp up.
    pulse(1'b1, 1'b0);
    check("up_lamp", int'(lampada), 1);
    tick(3); check("up_d0", int'(duty), 0);
    tick(1); check("up_d1", int'(duty), 1);
    tick(1016); check("up_d255", int'(duty), 255);
    check("up_en_early", int'(enable), 0);
    tick(1); check("on_en", int'(enable), 1);
    ones = 0;
    repeat (255) begin tick(1); if (pwm_out) ones++; end
    check("on_pwm_ones", ones, 255);

    // Timer shutdown ramp down.
    pulse(1'b0, 1'b1);
    check("c_en", int'(enable), 0);
    check("c_lamp", int'(lampada), 0);
    tick(4); check("dn_d254", int'(duty), 254);
    tick(1016); check("dn_d0", int'(duty), 0);
    tick(1);
    ones = 0;
    repeat (255) begin tick(1); if (pwm_out) ones++; end
    check("off_pwm_ones", ones, 0);

    // Simultaneous A and C in LIGADA.
    pulse(1'b1, 1'b0);
    tick(1021); check("ac_pre_en", int'(enable), 1);
    pulse(1'b1, 1'b1);
    check("ac_en", int'(enable), 0);
    check("ac_lamp", int'(lampada), 0);
    tick(4); check("ac_d254", int'(duty), 254);
    check("ac_lamp2", int'(lampada), 0);
    tick(1017); check("ac_off_lamp", int'(lampada), 0);

    // Reversals mid-ramp.
    pulse(1'b1, 1'b0);
    tick(400); check("rv_d100", int'(duty), 100);
    pulse(1'b1, 1'b0);
    check("rv_dn_lamp", int'(lampada), 0);
    check("rv_kept", int'(duty), 100);
    tick(4); check("rv_d99", int'(duty), 99);
    tick(156); check("rv_d60", int'(duty), 60);
    pulse(1'b1, 1'b0);
    check("rv_up_lamp", int'(lampada), 1);
    check("rv_kept2", int'(duty), 60);
    tick(4); check("rv_d61", int'(duty), 61);

    // C ignored outside LIGADA.
    pulse(1'b0, 1'b1);
    check("c_up_lamp", int'(lampada), 1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    check("c_dn_lamp", int'(lampada), 0);
    tick(260);
    pulse(1'b0, 1'b1);
    tick(5);
    check("c_off_lamp", int'(lampada), 0);
    check("c_off_duty", int'(duty), 0);

    // Asynchronous reset mid-ramp.
    pulse(1'b1, 1'b0);
    tick(148); check("rs_d37", int'(duty), 37);
    #2 rst = 1'b1;
    #1;
    check("rs_duty", int'(duty), 0);
    check("rs_lamp", int'(lampada), 0);
    check("rs_en",   int'(enable), 0);
    check("rs_pwm",  int'(pwm_out), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(5);
    check("rs_after_duty", int'(duty), 0);
    check("rs_after_lamp", int'(lampada), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/controle_lampada.md
Name: controle_lampada

Overview:
Main lamp controller, directly downstream of the auto-shutdown timer in Controladora. It consumes the timer's one-cycle shutdown pulse C and the debounced button pulse, and drives the timer's enable input. It runs a four-state on/off FSM with soft-start/soft-stop brightness ramps and generates the lamp PWM output.

Parameters:
RAMP_STEP_T, 100, clock cycles per one-LSB change of duty during a ramp; legal range 1..65535.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
A  input  1  debounced button pulse, one cycle high per press; toggle request
C  input  1  auto-shutdown pulse from the timer, one cycle high
enable  output  1  drives timer enable; 1 only while lamp fully on
lampada  output  1  lamp logically on (ramping up or fully on)
duty  output  8  current brightness, 0..255
pwm_out  output  1  registered PWM drive to lamp

Behaviour:
- Reset (async, rst=1): estado=DESLIGADA, duty=0, step_cnt=0, pwm_cnt=0, pwm_out=0, enable=0, lampada=0 immediately, with no clock needed. Reset mid-ramp aborts the ramp; nothing is retained.
- States: DESLIGADA, SUBINDO, LIGADA, DESCENDO. Encoded enum; any illegal state goes to DESLIGADA with duty=0.
- DESLIGADA: A=1 -> SUBINDO. C ignored.
- SUBINDO: if duty==255 -> LIGADA (checked first). Otherwise A=1 -> DESCENDO, with duty kept at its current value. Otherwise step_cnt increments; when step_cnt==RAMP_STEP_T-1, duty<=duty+1 and step_cnt<=0. C ignored.
- LIGADA: A=1 or C=1 -> DESCENDO. Simultaneous A and C produce a single transition to DESCENDO, not a double toggle.
- DESCENDO: if duty==0 -> DESLIGADA (checked first). Otherwise A=1 -> SUBINDO, with duty kept. Otherwise, on step_cnt==RAMP_STEP_T-1, duty<=duty-1 and step_cnt<=0. C ignored.
- step_cnt: 16-bit. Cleared to 0 on every state change, so the first step occurs RAMP_STEP_T cycles after entry.
- Duty saturation: duty never wraps. Increments stop at 255 and decrements stop at 0, because the saturating-state checks precede the step logic.
- Full ramp latency: A sampled at edge N -> SUBINDO at N. duty=255 at N+255*RAMP_STEP_T. LIGADA one edge later. Ramp-down has the same latency.
- enable = (estado==LIGADA). The timer therefore counts only while fully on, and C arriving in any other state is ignored.
- lampada = (estado==SUBINDO || estado==LIGADA). Both outputs are decoded from the registered state.
- PWM:
  - pwm_cnt is 8-bit and counts 0..254 then wraps to 0 (period 255 cycles).
  - pwm_out is registered: pwm_out <= (pwm_cnt < duty).
  - duty=0 gives a constant 0; duty=255 gives a constant 1.
  - One cycle of latency from duty/pwm_cnt to pwm_out.
  - pwm_cnt runs free in all states.
- A held high for several cycles is treated as one pulse per cycle; the upstream debouncer guarantees single-cycle pulses.

Test Plan (RAMP_STEP_T=4):
1. Reset then idle 50 cycles -> duty=0, pwm_out=0, enable=0, lampada=0. Assert rst asynchronously mid-cycle during SUBINDO with duty=37 -> all outputs 0 before the next edge.
2. A pulse at cycle 10 -> lampada=1 at the next edge; duty=1 four cycles later; duty=255 after 1020 cycles; enable=1 one cycle after that; pwm_out constant 1 in LIGADA.
3. In LIGADA, C pulse -> enable=0 next edge, duty decrements every 4 cycles to 0, then DESLIGADA, with lampada=0 throughout the ramp-down.
4. A and C high in the same cycle in LIGADA -> single DESCENDO entry; not returned to SUBINDO.
5. A at duty=100 during SUBINDO -> DESCENDO, duty=99 four cycles later. A again at duty=60 -> SUBINDO, duty=61 four cycles later.
6. Force duty=128 and hold the state -> pwm_out high for exactly 128 of every 255 cycles. C pulses in DESLIGADA/SUBINDO/DESCENDO -> no state change.
